regfile_2r1w: RTL

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w_if.sv | 27 ++
 rtl/regfile_2r1w.sv | 93 +++++++++
 2 files changed

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port and two registered read ports.
interface regfile_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic              re0;
    logic [ADDR_W-1:0] rAddr0;
    logic [DATA_W-1:0] rData0;
    logic              rValid0;
    logic              re1;
    logic [ADDR_W-1:0] rAddr1;
    logic [DATA_W-1:0] rData1;
    logic              rValid1;

    modport master (
        output we, wAddr, wData, re0, rAddr0, re1, rAddr1,
        input  rData0, rValid0, rData1, rValid1
    );

    modport slave (
        input  we, wAddr, wData, re0, rAddr0, re1, rAddr1,
        output rData0, rValid0, rData1, rValid1
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered read data.
// Define REGFILE_2R1W_BYPASS_EN for write-first read-during-write; default is read-first.
module regfile_2r1w_rport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] rData,
    output logic              rValid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            rData  <= '0;
            rValid <= 1'b0;
        end else begin
            rValid <= re;
            if (re) rData <= word;
        end
    end
endmodule

module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input logic           clk,
    input logic           reset,
    regfile_2r1w_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NUM_RD = 2;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrReq_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
    } rdReq_t;

    wrReq_t                         wr;
    rdReq_t [NUM_RD-1:0]            rd;
    logic   [DEPTH-1:0][DATA_W-1:0]  mem;
    logic   [NUM_RD-1:0][DATA_W-1:0] rData;
    logic   [NUM_RD-1:0]            rValid;

    // Writes to entry 0 are dropped at the source when it is hardwired to zero.
    assign wr.en   = bus.we && !(ZERO_REG != 0 && bus.wAddr == '0);
    assign wr.addr = bus.wAddr;
    assign wr.data = bus.wData;

    assign rd[0].en   = bus.re0;
    assign rd[0].addr = bus.rAddr0;
    assign rd[1].en   = bus.re1;
    assign rd[1].addr = bus.rAddr1;

    always_ff @(posedge clk) begin
        if (reset) mem <= '0;
        else if (wr.en) mem[wr.addr] <= wr.data;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRd
        logic [DATA_W-1:0] rdWord;

        always_comb begin
            rdWord = mem[rd[p].addr];
`ifdef REGFILE_2R1W_BYPASS_EN
            if (wr.en && wr.addr == rd[p].addr) rdWord = wr.data;
`endif
            if (ZERO_REG != 0 && rd[p].addr == '0) rdWord = '0;
        end

        regfile_2r1w_rport #(.DATA_W(DATA_W)) uPort (
            .clk    (clk),
            .reset  (reset),
            .re     (rd[p].en),
            .word   (rdWord),
            .rData  (rData[p]),
            .rValid (rValid[p])
        );
    end

    assign bus.rData0  = rData[0];
    assign bus.rValid0 = rValid[0];
    assign bus.rData1  = rData[1];
    assign bus.rValid1 = rValid[1];
endmodule
